// File: rtl/sample_acq_pkg.sv
// Shared definitions for the sample acquisition responder: register map,
// CTRL command / status bit positions and the acquisition state type.
package sample_acq_pkg;

  localparam logic [13:0] ADDR_ID     = 14'd0;
  localparam logic [13:0] ADDR_CTRL   = 14'd1;
  localparam logic [13:0] ADDR_LEVEL  = 14'd2;
  localparam logic [13:0] ADDR_THRESH = 14'd3;
  localparam logic [13:0] ADDR_DATA   = 14'd4;

  localparam int CTRL_START = 0;
  localparam int CTRL_STOP  = 1;
  localparam int CTRL_ACK   = 2;
  localparam int CTRL_FLUSH = 3;

  localparam int ST_ACTIVE = 0;
  localparam int ST_IRQ    = 1;
  localparam int ST_OVF    = 2;
  localparam int ST_EMPTY  = 3;
  localparam int ST_FULL   = 4;
  localparam int ST_HALTED = 5;

  localparam logic [15:0] ID_DEFAULT = 16'h5A3C;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    HALTED  = 2'd2
  } state_t;

endpackage

// File: rtl/sample_acq_fifo.sv
// Synchronous sample FIFO with push, pop and flush; flush overrides both.
// A pop frees the slot a same-cycle push needs, so a full FIFO accepts push+pop.
module sample_acq_fifo
  import sample_acq_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic                     avl_clk_i,
  input  logic                     avl_reset_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [15:0]              wdata_i,
  output logic [15:0]              rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     push_done_o,
  output logic                     pop_done_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [15:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;

  assign empty_o     = (count_q == '0);
  assign full_o      = (count_q == (AW+1)'(DEPTH));
  assign pop_done_o  = pop_i && !empty_o;
  assign push_done_o = push_i && (!full_o || pop_done_o);
  assign rdata_o     = mem_q[rd_ptr_q];
  assign count_o     = count_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge avl_clk_i or negedge avl_reset_i) begin
    if (!avl_reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_done_o) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_done_o)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + (AW+1)'(push_done_o) - (AW+1)'(pop_done_o);
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count define
  // which entries are meaningful, and a reset here would block RAM inference.
  always_ff @(posedge avl_clk_i) begin
    if (push_done_o && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/sample_acq_responder.sv
// Avalon-MM responder capturing samples into a FIFO with threshold/overflow IRQ.
// Define SAMPLE_ACQ_HALT_ON_OVF_EN to halt acquisition on the first overflow.
module sample_acq_responder
  import sample_acq_pkg::*;
#(
  parameter int          FIFO_DEPTH = 64,
  parameter logic [15:0] ID_VALUE   = ID_DEFAULT,
  parameter int          THRESH_RST = 8
) (
  input  logic        avl_clk_i,
  input  logic        avl_reset_i,
  input  logic [13:0] avl_address_i,
  input  logic [3:0]  avl_byteenable_i,
  input  logic        avl_write_i,
  input  logic [15:0] avl_writedata_i,
  input  logic        avl_read_i,
  output logic        avl_readdatavalid_o,
  output logic [15:0] avl_readdata_o,
  output logic        avl_waitrequest_o,
  output logic        avl_irq_o,
  input  logic [15:0] sample_i,
  input  logic        sample_valid_i
);

  localparam int          AW          = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] THRESH_INIT = (AW+1)'(THRESH_RST);

  state_t      state_q, state_d;
  logic        rdy_q, waitreq_q, rdv_q;
  logic [15:0] rdata_q, rdata_d, status;
  logic        ovf_q, ovf_d, irq_q, irq_d;
  logic [AW:0] thresh_q, thresh_d, level;
  logic        rd_acc, wr_acc, wr_ctrl;
  logic        cmd_start, cmd_stop, cmd_ack, cmd_flush;
  logic        push_req, pop_req, push_done, pop_done;
  logic        ovf_event, thresh_hit, halted;
  logic        fifo_full, fifo_empty;
  logic [15:0] fifo_head;
  logic        unused_bits;

  assign unused_bits = ^{avl_byteenable_i, avl_writedata_i[15:AW+1]};

  // A read and a write in the same cycle: the read is served, the write dropped.
  assign rd_acc    = avl_read_i && !waitreq_q;
  assign wr_acc    = avl_write_i && !waitreq_q && !avl_read_i;
  assign wr_ctrl   = wr_acc && (avl_address_i == ADDR_CTRL);
  assign cmd_start = wr_ctrl && avl_writedata_i[CTRL_START];
  assign cmd_stop  = wr_ctrl && avl_writedata_i[CTRL_STOP];
  assign cmd_ack   = wr_ctrl && avl_writedata_i[CTRL_ACK];
  assign cmd_flush = wr_ctrl && avl_writedata_i[CTRL_FLUSH];

  assign push_req   = sample_valid_i && (state_q == ACQUIRE);
  assign pop_req    = rd_acc && (avl_address_i == ADDR_DATA);
  assign ovf_event  = push_req && fifo_full && !pop_done && !cmd_flush;
  assign thresh_hit = push_done && !pop_done && !cmd_flush && (thresh_q != '0)
                      && ((level + (AW+1)'(1)) == thresh_q);

`ifdef SAMPLE_ACQ_HALT_ON_OVF_EN
  assign halted = (state_q == HALTED);
`else
  assign halted = 1'b0;
`endif

  sample_acq_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .avl_clk_i   (avl_clk_i),
    .avl_reset_i (avl_reset_i),
    .push_i      (push_req),
    .pop_i       (pop_req),
    .flush_i     (cmd_flush),
    .wdata_i     (sample_i),
    .rdata_o     (fifo_head),
    .count_o     (level),
    .push_done_o (push_done),
    .pop_done_o  (pop_done),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cmd_start && !cmd_stop) state_d = ACQUIRE;
      ACQUIRE: begin
        if (cmd_stop) state_d = IDLE;
`ifdef SAMPLE_ACQ_HALT_ON_OVF_EN
        else if (ovf_event) state_d = HALTED;
`endif
      end
      HALTED: begin
        if (cmd_stop || cmd_flush) state_d = IDLE;
        else if (cmd_start)        state_d = ACQUIRE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: every output of this block gets a default first so no path leaves
  // a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    ovf_d    = ovf_q;
    irq_d    = irq_q;
    thresh_d = thresh_q;
    rdata_d  = rdata_q;
    status   = '0;
    status[ST_ACTIVE] = (state_q == ACQUIRE);
    status[ST_IRQ]    = irq_q;
    status[ST_OVF]    = ovf_q;
    status[ST_EMPTY]  = fifo_empty;
    status[ST_FULL]   = fifo_full;
    status[ST_HALTED] = halted;

    if (cmd_flush)      ovf_d = 1'b0;
    else if (ovf_event) ovf_d = 1'b1;

    if (thresh_hit || (ovf_event && !ovf_q)) irq_d = 1'b1;
    else if (cmd_ack)                        irq_d = 1'b0;

    if (wr_acc && (avl_address_i == ADDR_THRESH)) thresh_d = avl_writedata_i[AW:0];

    if (rd_acc) begin
      case (avl_address_i)
        ADDR_ID:     rdata_d = ID_VALUE;
        ADDR_CTRL:   rdata_d = status;
        ADDR_LEVEL:  rdata_d = 16'(level);
        ADDR_THRESH: rdata_d = 16'(thresh_q);
        ADDR_DATA:   rdata_d = fifo_empty ? 16'h0 : fifo_head;
        default:     rdata_d = 16'h0;
      endcase
    end
  end

  always_ff @(posedge avl_clk_i or negedge avl_reset_i) begin
    if (!avl_reset_i) begin
      state_q   <= IDLE;
      rdy_q     <= 1'b0;
      waitreq_q <= 1'b1;
      rdv_q     <= 1'b0;
      rdata_q   <= '0;
      ovf_q     <= 1'b0;
      irq_q     <= 1'b0;
      thresh_q  <= THRESH_INIT;
    end else begin
      state_q   <= state_d;
      rdy_q     <= 1'b1;
      waitreq_q <= !rdy_q;
      rdv_q     <= rd_acc;
      rdata_q   <= rdata_d;
      ovf_q     <= ovf_d;
      irq_q     <= irq_d;
      thresh_q  <= thresh_d;
    end
  end

  assign avl_waitrequest_o   = waitreq_q;
  assign avl_readdatavalid_o = rdv_q;
  assign avl_readdata_o      = rdata_q;
  assign avl_irq_o           = irq_q;

endmodule

// File: tb/tb_sample_acq_responder.sv
// Bench for sample_acq_responder: register table, directed corner sequences and
// a randomized phase checked against a queue-based model of the block.
`timescale 1ns/1ps
module tb_sample_acq_responder;

  localparam int DEPTH = 64;
  localparam int M_IDLE = 0, M_ACQ = 1, M_HALT = 2;
`ifdef SAMPLE_ACQ_HALT_ON_OVF_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [13:0] addr;
  logic [3:0]  be;
  logic        wr, rd, svalid;
  logic [15:0] wdata, sample;
  logic        rdv, waitreq, irq;
  logic [15:0] rdata;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sample_acq_responder #(.FIFO_DEPTH(DEPTH), .ID_VALUE(16'h5A3C), .THRESH_RST(8)) dut (
    .avl_clk_i           (clk),
    .avl_reset_i         (rst_n),
    .avl_address_i       (addr),
    .avl_byteenable_i    (be),
    .avl_write_i         (wr),
    .avl_writedata_i     (wdata),
    .avl_read_i          (rd),
    .avl_readdatavalid_o (rdv),
    .avl_readdata_o      (rdata),
    .avl_waitrequest_o   (waitreq),
    .avl_irq_o           (irq),
    .sample_i            (sample),
    .sample_valid_i      (svalid)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; rd = 1'b0; wr = 1'b0; svalid = 1'b0;
    addr = '0; wdata = '0; sample = '0; be = 4'hF;
    repeat (3) tick();
    check("rst_rdv", rdv, 1'b0);
    check("rst_rdata", rdata, 16'h0);
    check("rst_irq", irq, 1'b0);
    check("rst_waitreq", waitreq, 1'b1);
    rst_n = 1'b1;
    tick();
    check("waitreq_edge1", waitreq, 1'b1);
    tick();
    check("waitreq_edge2", waitreq, 1'b0);
  endtask

  task automatic bus_write(input logic [13:0] a, input logic [15:0] d);
    addr = a; wdata = d; wr = 1'b1;
    tick();
    wr = 1'b0;
  endtask

  task automatic bus_read(input logic [13:0] a, output logic [15:0] d);
    addr = a; rd = 1'b1;
    tick();
    rd = 1'b0;
    check("rdv_pulse", rdv, 1'b1);
    d = rdata;
    tick();
    check("rdv_drop", rdv, 1'b0);
  endtask

  task automatic read_check(input string name, input logic [13:0] a, input logic [15:0] exp);
    logic [15:0] got;
    bus_read(a, got);
    check(name, got, exp);
  endtask

  task automatic push(input logic [15:0] v);
    sample = v; svalid = 1'b1;
    tick();
    svalid = 1'b0;
  endtask

  // Behavioural model: FIFO contents as a queue, flags as plain bits.
  int          m_mode;
  logic [15:0] m_q[$];
  bit          m_ovf, m_irq;
  int          m_thr;

  task automatic model_step(input bit r, input bit w, input int a, input logic [15:0] d,
                            input bit v, input logic [15:0] s,
                            output bit e_rdv, output logic [15:0] e_rd);
    bit wr_ok   = w && !r;
    bit is_ctrl = wr_ok && (a == 1);
    bit start   = is_ctrl && d[0];
    bit stop    = is_ctrl && d[1];
    bit ack     = is_ctrl && d[2];
    bit flush   = is_ctrl && d[3];
    bit popped  = 1'b0;
    bit pushed  = 1'b0;
    bit ovf_ev  = 1'b0;
    e_rdv = r;
    e_rd  = '0;
    if (r) begin
      case (a)
        0: e_rd = 16'h5A3C;
        1: e_rd = 16'({m_mode == M_HALT, m_q.size() == DEPTH, m_q.size() == 0,
                       m_ovf, m_irq, m_mode == M_ACQ});
        2: e_rd = 16'(m_q.size());
        3: e_rd = 16'(m_thr);
        4: e_rd = (m_q.size() > 0) ? m_q[0] : 16'h0;
        default: e_rd = 16'h0;
      endcase
    end
    if (flush) begin
      m_q.delete();
      m_ovf = 1'b0;
    end else begin
      if (r && (a == 4) && (m_q.size() > 0)) begin
        void'(m_q.pop_front());
        popped = 1'b1;
      end
      if (v && (m_mode == M_ACQ)) begin
        if (m_q.size() < DEPTH) begin
          m_q.push_back(s);
          pushed = 1'b1;
        end else begin
          ovf_ev = 1'b1;
        end
      end
    end
    if ((pushed && !popped && (m_thr != 0) && (m_q.size() == m_thr)) || (ovf_ev && !m_ovf))
      m_irq = 1'b1;
    else if (ack)
      m_irq = 1'b0;
    if (ovf_ev) m_ovf = 1'b1;
    case (m_mode)
      M_IDLE: if (start && !stop) m_mode = M_ACQ;
      M_ACQ: begin
        if (stop) m_mode = M_IDLE;
        else if (ovf_ev && HALT_EN) m_mode = M_HALT;
      end
      default: begin
        if (stop || flush) m_mode = M_IDLE;
        else if (start) m_mode = M_ACQ;
      end
    endcase
    if (wr_ok && (a == 3)) m_thr = int'(d) & (2 * DEPTH - 1);
  endtask

  typedef struct packed {
    bit          is_wr;
    logic [13:0] a;
    logic [15:0] d;
    logic [15:0] exp;
  } vec_t;

  localparam int NV = 21;
  vec_t tbl [NV];

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] got;
    int          op;
    bit          quiet, e_rdv;
    logic [15:0] e_rd;

    tbl = '{
      '{1'b0, 14'd0,      16'h0,    16'h5A3C},
      '{1'b0, 14'd1,      16'h0,    16'h0008},
      '{1'b0, 14'd2,      16'h0,    16'h0000},
      '{1'b0, 14'd3,      16'h0,    16'h0008},
      '{1'b1, 14'd3,      16'h01FF, 16'h0},
      '{1'b0, 14'd3,      16'h0,    16'h007F},
      '{1'b1, 14'd3,      16'h0005, 16'h0},
      '{1'b0, 14'd3,      16'h0,    16'h0005},
      '{1'b0, 14'd5,      16'h0,    16'h0000},
      '{1'b0, 14'h3FFF,   16'h0,    16'h0000},
      '{1'b1, 14'd0,      16'h1234, 16'h0},
      '{1'b0, 14'd0,      16'h0,    16'h5A3C},
      '{1'b0, 14'd4,      16'h0,    16'h0000},
      '{1'b0, 14'd2,      16'h0,    16'h0000},
      '{1'b1, 14'd1,      16'h0001, 16'h0},
      '{1'b0, 14'd1,      16'h0,    16'h0009},
      '{1'b1, 14'd1,      16'h0003, 16'h0},
      '{1'b0, 14'd1,      16'h0,    16'h0008},
      '{1'b1, 14'd1,      16'h0001, 16'h0},
      '{1'b1, 14'd1,      16'h0002, 16'h0},
      '{1'b0, 14'd1,      16'h0,    16'h0008}
    };

    do_reset();

    for (int i = 0; i < NV; i++) begin
      if (tbl[i].is_wr) bus_write(tbl[i].a, tbl[i].d);
      else begin
        bus_read(tbl[i].a, got);
        check($sformatf("tbl%0d", i), got, tbl[i].exp);
      end
    end

    // Simultaneous read and write of THRESH: read served, write ignored.
    addr = 14'd3; wdata = 16'd2; rd = 1'b1; wr = 1'b1;
    tick();
    rd = 1'b0; wr = 1'b0;
    check("rdwr_rdata", rdata, 16'd5);
    tick();
    read_check("rdwr_thresh_kept", 14'd3, 16'd5);

    // Threshold interrupt, back-to-back DATA pops, then ack.
    bus_write(14'd3, 16'd4);
    bus_write(14'd1, 16'd1);
    push(16'd10); push(16'd20); push(16'd30);
    check("irq_before_thresh", irq, 1'b0);
    push(16'd40);
    check("irq_at_thresh", irq, 1'b1);
    read_check("thr_level", 14'd2, 16'd4);
    addr = 14'd4; rd = 1'b1;
    tick();
    check("b2b_rdv0", rdv, 1'b1);
    check("b2b_data0", rdata, 16'd10);
    tick();
    rd = 1'b0;
    check("b2b_rdv1", rdv, 1'b1);
    check("b2b_data1", rdata, 16'd20);
    tick();
    check("b2b_rdv_end", rdv, 1'b0);
    read_check("data3", 14'd4, 16'd30);
    read_check("data4", 14'd4, 16'd40);
    read_check("data_empty", 14'd4, 16'd0);
    read_check("level_empty", 14'd2, 16'd0);
    check("irq_held", irq, 1'b1);
    bus_write(14'd1, 16'd4);
    check("irq_acked", irq, 1'b0);
    read_check("status_after_ack", 14'd1, 16'h0009);

    // Overflow with threshold disabled.
    bus_write(14'd3, 16'd0);
    for (int i = 1; i <= DEPTH; i++) push(16'(i));
    check("irq_full_no_ovf", irq, 1'b0);
    push(16'd65);
    check("irq_ovf", irq, 1'b1);
    read_check("ovf_level", 14'd2, 16'd64);
`ifdef SAMPLE_ACQ_HALT_ON_OVF_EN
    read_check("ovf_status_halt", 14'd1, 16'h0036);
    bus_write(14'd1, 16'd8);
    read_check("flush_level", 14'd2, 16'd0);
    read_check("flush_status", 14'd1, 16'h000A);
`else
    read_check("ovf_status_run", 14'd1, 16'h0017);
    read_check("ovf_head", 14'd4, 16'd1);
`endif

    // Full FIFO: push and pop in the same cycle keeps LEVEL, no overflow.
    bus_write(14'd1, 16'd8);
    bus_write(14'd1, 16'd4);
    bus_write(14'd1, 16'd1);
    for (int i = 1; i <= DEPTH; i++) push(16'(i));
    read_check("conc_status_full", 14'd1, 16'h0011);
    addr = 14'd4; rd = 1'b1; sample = 16'd500; svalid = 1'b1;
    tick();
    rd = 1'b0; svalid = 1'b0;
    check("conc_pop_data", rdata, 16'd1);
    tick();
    read_check("conc_level", 14'd2, 16'd64);
    read_check("conc_status", 14'd1, 16'h0011);
    bus_write(14'd1, 16'd3);
    read_check("conc_stopped", 14'd1, 16'h0010);

    // Reset asserted while a read response is outstanding.
    addr = 14'd0; rd = 1'b1;
    tick();
    rst_n = 1'b0;
    #1;
    check("rst_mid_rdv", rdv, 1'b0);
    check("rst_mid_rdata", rdata, 16'h0);
    rd = 1'b0;
    tick();
    check("rst_mid_rdv_held", rdv, 1'b0);

    // Randomized phase against the model.
    do_reset();
    m_mode = M_IDLE; m_q.delete(); m_ovf = 1'b0; m_irq = 1'b0; m_thr = 8;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      quiet  = ((cyc / 300) % 2) == 1;
      op     = $urandom_range(0, 31);
      rd     = 1'b0;
      wr     = 1'b0;
      svalid = ($urandom_range(0, 3) != 0);
      sample = 16'($urandom);
      be     = 4'($urandom);
      addr   = 14'd0;
      wdata  = 16'd0;
      if (op >= 18 && op <= 21) begin
        rd = 1'b1; addr = 14'($urandom_range(0, 5));
      end else if (op >= 22 && op <= 24) begin
        rd = 1'b1; addr = 14'd4;
      end else if (op == 25 && !quiet) begin
        wr = 1'b1; addr = 14'd1; wdata = 16'($urandom_range(0, 15));
      end else if (op == 26 || op == 27) begin
        wr = 1'b1; addr = 14'd3; wdata = 16'($urandom_range(0, 12));
      end else if (op == 28) begin
        wr = 1'b1; addr = 14'd1; wdata = 16'd1;
      end else if (op == 29) begin
        wr = 1'b1; addr = 14'd1; wdata = 16'd4;
      end else if (op == 30 && !quiet) begin
        rd = 1'b1; wr = 1'b1; addr = 14'($urandom_range(1, 3));
        wdata = 16'($urandom_range(0, 15));
      end
      model_step(rd, wr, int'(addr), wdata, svalid, sample, e_rdv, e_rd);
      tick();
      check("rnd_rdv", rdv, e_rdv);
      if (e_rdv) check($sformatf("rnd_rdata_a%0d_c%0d", addr, cyc), rdata, e_rd);
      check($sformatf("rnd_irq_c%0d", cyc), irq, m_irq);
    end
    rd = 1'b0; wr = 1'b0; svalid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
